// File: rtl/hazard_pkg.sv
// Shared constants and the scoreboard entry record for the D-stage hazard unit.
// Entry fields are sized for the widest supported core; narrower ports are zero-extended into them.
package hazard_pkg;

  localparam int SB_ADDR_W = 8;
  localparam int SB_TNEW_W = 4;

  localparam logic [2:0] TNEW_NONE = 3'd0;
  localparam logic [2:0] TNEW_CALC = 3'd1;
  localparam logic [2:0] TNEW_LOAD = 3'd2;

  localparam logic [2:0] TUSE_BRANCH   = 3'd0;
  localparam logic [2:0] TUSE_ALU      = 3'd1;
  localparam logic [2:0] TUSE_STORE_RT = 3'd2;
  localparam logic [2:0] TUSE_NONE     = 3'b111;

  typedef struct packed {
    logic                 valid;
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_TNEW_W-1:0] tnew;
  } sb_entry_t;

  function automatic logic [SB_TNEW_W-1:0] tnew_dec(input logic [SB_TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - SB_TNEW_W'(1);
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Multiply/divide occupancy counter: loads the operation latency on issue, then counts down.
module md_busy_counter #(
  parameter  int MULT_LAT = 5,
  parameter  int DIV_LAT  = 10,
  localparam int MAX_LAT  = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT,
  localparam int CW       = $clog2(MAX_LAT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic div_i,
  output logic busy_o
);

  logic [CW-1:0] count_d, count_q;

  // NOTE: count_d takes a default first so every path assigns it and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (start_i) begin
      count_d = div_i ? CW'(DIV_LAT) : CW'(MULT_LAT);
    end else if (count_q != '0) begin
      count_d = count_q - CW'(1);
    end
  end

  // NOTE: state registers use <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Combinational from the register, so an asynchronous reset drops busy immediately.
  assign busy_o = (count_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// D-stage stall and forward-select unit built on a shifting scoreboard of in-flight
// register writes (stage 1 = E .. DEPTH = W), plus the HI/LO busy interlock.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter  int NREG     = 32,
  parameter  int DEPTH    = 3,
  parameter  int TW       = 3,
  parameter  int MULT_LAT = 5,
  parameter  int DIV_LAT  = 10,
  localparam int AW       = $clog2(NREG),
  localparam int SW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          d_valid,
  input  logic [AW-1:0] d_rs,
  input  logic [AW-1:0] d_rt,
  input  logic [TW-1:0] d_tuse_rs,
  input  logic [TW-1:0] d_tuse_rt,
  input  logic [AW-1:0] d_wr_addr,
  input  logic [TW-1:0] d_tnew,
  input  logic          d_hilo_use,
  input  logic          d_md_start,
  input  logic          d_md_div,
  output logic          stall,
  output logic [SW-1:0] fwd_rs_sel,
  output logic [SW-1:0] fwd_rt_sel,
  output logic          md_busy
);

  logic [SB_ADDR_W-1:0] rs_ext, rt_ext;
  logic [SB_TNEW_W-1:0] tuse_rs_ext, tuse_rt_ext;
  sb_entry_t            entry_new;
  sb_entry_t            sb_q [1:DEPTH];
  logic [DEPTH:1]       match_rs, match_rt, late_rs, late_rt;
  logic                 md_issue;

  assign rs_ext      = SB_ADDR_W'(d_rs);
  assign rt_ext      = SB_ADDR_W'(d_rt);
  // An unused source carries all-ones Tuse, which no Tnew can exceed.
  assign tuse_rs_ext = SB_TNEW_W'(d_tuse_rs);
  assign tuse_rt_ext = SB_TNEW_W'(d_tuse_rt);

  // A stalled D slot enters E as a bubble; writes to $0 are never recorded.
  assign entry_new = '{valid: d_valid && !stall && (d_wr_addr != '0),
                       addr:  SB_ADDR_W'(d_wr_addr),
                       tnew:  SB_TNEW_W'(d_tnew)};

  for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
    sb_entry_t entry_d, entry_q;

    if (k == 1) begin : g_head
      assign entry_d = entry_new;
    end else begin : g_shift
      assign entry_d = '{valid: sb_q[k-1].valid,
                         addr:  sb_q[k-1].addr,
                         tnew:  tnew_dec(sb_q[k-1].tnew)};
    end

    // NOTE: the whole entry is reset, not just valid, so no X ever reaches the compare logic.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        entry_q <= '0;
      end else if (flush) begin
        entry_q <= '0;
      end else begin
        entry_q <= entry_d;
      end
    end

    assign sb_q[k]     = entry_q;
    assign match_rs[k] = entry_q.valid && (entry_q.addr != '0) && (entry_q.addr == rs_ext);
    assign match_rt[k] = entry_q.valid && (entry_q.addr != '0) && (entry_q.addr == rt_ext);
    assign late_rs[k]  = tuse_rs_ext < entry_q.tnew;
    assign late_rt[k]  = tuse_rt_ext < entry_q.tnew;
  end

  // Youngest producer wins: scan from the oldest stage so the lowest match overwrites.
  always_comb begin
    fwd_rs_sel = '0;
    fwd_rt_sel = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (match_rs[k]) fwd_rs_sel = SW'(k);
      if (match_rt[k]) fwd_rt_sel = SW'(k);
    end
  end

  assign stall = d_valid && ((|(match_rs & late_rs)) ||
                             (|(match_rt & late_rt)) ||
                             (d_hilo_use && md_busy));

  // A flush squashes the issuing instruction, but never an operation already running.
  assign md_issue = d_valid && d_md_start && !stall && !flush;

  md_busy_counter #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_md_busy_counter (
    .clk     (clk),
    .rst_n   (reset),
    .start_i (md_issue),
    .div_i   (d_md_div),
    .busy_o  (md_busy)
  );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a producer-age model checked every cycle,
// plus hand-computed expectations for the key pipeline scenarios.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam int DEPTH    = 3;
  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       flush = 1'b0;
  logic       d_valid = 1'b0;
  logic [4:0] d_rs = '0, d_rt = '0, d_wr_addr = '0;
  logic [2:0] d_tuse_rs = TUSE_NONE, d_tuse_rt = TUSE_NONE, d_tnew = TNEW_NONE;
  logic       d_hilo_use = 1'b0, d_md_start = 1'b0, d_md_div = 1'b0;
  logic       stall;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;
  logic       md_busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .NREG(32), .DEPTH(DEPTH), .TW(3), .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .d_valid(d_valid),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_wr_addr(d_wr_addr), .d_tnew(d_tnew), .d_hilo_use(d_hilo_use),
    .d_md_start(d_md_start), .d_md_div(d_md_div),
    .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .md_busy(md_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: each recorded write knows the edge it entered E; its stage and remaining
  // Tnew follow from its age. The HI/LO unit is busy for LAT cycles after its issue edge.
  typedef struct {
    int n_issue;
    int addr;
    int tnew;
  } wr_rec_t;

  wr_rec_t inflight[$];
  int      n_edge        = 0;
  int      md_issue_edge = 0;
  int      md_lat        = 0;

  function automatic void model_eval(output bit st, output int frs, output int frt,
                                     output bit busy);
    busy = (md_lat > 0) && ((n_edge - md_issue_edge) < md_lat);
    st   = d_valid && d_hilo_use && busy;
    frs  = 0;
    frt  = 0;
    foreach (inflight[i]) begin
      int stage, tn;
      stage = n_edge - inflight[i].n_issue + 1;
      tn    = inflight[i].tnew - (stage - 1);
      if (tn < 0) tn = 0;
      if (stage > DEPTH || inflight[i].addr == 0) continue;
      if (inflight[i].addr == int'(d_rs)) begin
        if (frs == 0 || stage < frs) frs = stage;
        if (d_valid && int'(d_tuse_rs) < tn) st = 1'b1;
      end
      if (inflight[i].addr == int'(d_rt)) begin
        if (frt == 0 || stage < frt) frt = stage;
        if (d_valid && int'(d_tuse_rt) < tn) st = 1'b1;
      end
    end
  endfunction

  task automatic model_reset();
    inflight.delete();
    md_lat = 0;
    n_edge = 0;
  endtask

  task automatic model_step();
    bit      st, busy;
    int      frs, frt;
    wr_rec_t rec;
    if (!reset) return;
    model_eval(st, frs, frt, busy);
    if (flush) inflight.delete();
    n_edge++;
    if (!flush && d_valid && !st) begin
      if (d_wr_addr != 0) begin
        rec.n_issue = n_edge;
        rec.addr    = int'(d_wr_addr);
        rec.tnew    = int'(d_tnew);
        inflight.push_back(rec);
      end
      if (d_md_start) begin
        md_issue_edge = n_edge;
        md_lat        = d_md_div ? DIV_LAT : MULT_LAT;
      end
    end
  endtask

  // Every clock edge the bench lets pass goes through here, keeping the model in step.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (reset && chk_en) begin
        bit st, busy;
        int frs, frt;
        model_eval(st, frs, frt, busy);
        check("model_stall",  stall,      st);
        check("model_fwd_rs", fwd_rs_sel, frs);
        check("model_fwd_rt", fwd_rt_sel, frt);
        check("model_busy",   md_busy,    busy);
      end
    end
  end

  task automatic idle();
    d_valid = 0; d_rs = 0; d_rt = 0; d_wr_addr = 0;
    d_tuse_rs = TUSE_NONE; d_tuse_rt = TUSE_NONE; d_tnew = TNEW_NONE;
    d_hilo_use = 0; d_md_start = 0; d_md_div = 0;
  endtask

  task automatic instr(input logic [4:0] rs, input logic [4:0] rt, input logic [2:0] tu_rs,
                       input logic [2:0] tu_rt, input logic [4:0] wr, input logic [2:0] tn);
    d_valid = 1; d_rs = rs; d_rt = rt; d_tuse_rs = tu_rs; d_tuse_rt = tu_rt;
    d_wr_addr = wr; d_tnew = tn; d_hilo_use = 0; d_md_start = 0; d_md_div = 0;
  endtask

  // mult/div (start=1, wr=0) or mflo/mfhi (start=0, wr=dest)
  task automatic hilo(input logic start, input logic div, input logic [4:0] wr);
    instr(5'd8, 5'd9, TUSE_ALU, TUSE_ALU, wr, (wr != 0) ? TNEW_CALC : TNEW_NONE);
    d_hilo_use = 1; d_md_start = start; d_md_div = div;
  endtask

  task automatic drain();
    idle();
    repeat (3) tick();
  endtask

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("reset_stall",  stall,      0);
    check("reset_fwd_rs", fwd_rs_sel, 0);
    check("reset_fwd_rt", fwd_rt_sel, 0);
    check("reset_busy",   md_busy,    0);
    chk_en = 1'b1;

    // lw $2 ; addu $3,$2,$1 : one load-use bubble then forward from M
    instr(5'd1, 5'd0, TUSE_ALU, TUSE_NONE, 5'd2, TNEW_LOAD); tick();
    instr(5'd2, 5'd1, TUSE_ALU, TUSE_ALU, 5'd3, TNEW_CALC); #1;
    check("lu_stall", stall, 1);
    tick();
    check("lu_release", stall, 0);
    check("lu_fwd_rs", fwd_rs_sel, 2);
    check("lu_fwd_rt", fwd_rt_sel, 0);
    tick();
    drain();

    // addu $4 ; beq $4,$5 : one-cycle branch stall, then forward from M
    instr(5'd1, 5'd1, TUSE_ALU, TUSE_ALU, 5'd4, TNEW_CALC); tick();
    instr(5'd4, 5'd5, TUSE_BRANCH, TUSE_BRANCH, 5'd0, TNEW_NONE); #1;
    check("br_stall", stall, 1);
    tick();
    check("br_release", stall, 0);
    check("br_fwd_rs", fwd_rs_sel, 2);
    tick();
    drain();

    // same with a nop in between: no stall
    instr(5'd1, 5'd1, TUSE_ALU, TUSE_ALU, 5'd4, TNEW_CALC); tick();
    idle(); tick();
    instr(5'd4, 5'd5, TUSE_BRANCH, TUSE_BRANCH, 5'd0, TNEW_NONE); #1;
    check("br_nop_stall", stall, 0);
    check("br_nop_fwd_rs", fwd_rs_sel, 2);
    tick();
    drain();

    // writes to $0 never stall or forward
    instr(5'd1, 5'd1, TUSE_ALU, TUSE_ALU, 5'd0, TNEW_CALC); tick();
    instr(5'd0, 5'd0, TUSE_BRANCH, TUSE_BRANCH, 5'd3, TNEW_CALC); #1;
    check("r0_stall", stall, 0);
    check("r0_fwd_rs", fwd_rs_sel, 0);
    check("r0_fwd_rt", fwd_rt_sel, 0);
    tick();
    drain();

    // two writers of $6: the youngest (E) wins; store data needs no stall
    instr(5'd1, 5'd1, TUSE_ALU, TUSE_ALU, 5'd6, TNEW_CALC); tick();
    instr(5'd1, 5'd1, TUSE_ALU, TUSE_ALU, 5'd6, TNEW_CALC); tick();
    instr(5'd6, 5'd6, TUSE_ALU, TUSE_STORE_RT, 5'd0, TNEW_NONE); #1;
    check("prio_stall", stall, 0);
    check("prio_fwd_rs", fwd_rs_sel, 1);
    check("prio_fwd_rt", fwd_rt_sel, 1);
    tick();
    drain();

    // lw $9 two slots ahead of a branch: forward from W, no stall
    instr(5'd1, 5'd0, TUSE_ALU, TUSE_NONE, 5'd9, TNEW_LOAD); tick();
    idle(); repeat (2) tick();
    instr(5'd9, 5'd0, TUSE_BRANCH, TUSE_BRANCH, 5'd0, TNEW_NONE); #1;
    check("w_stall", stall, 0);
    check("w_fwd_rs", fwd_rs_sel, 3);
    tick();
    drain();

    // mult then mflo: busy and stalled for exactly MULT_LAT cycles
    hilo(1'b1, 1'b0, 5'd0); tick();
    hilo(1'b0, 1'b0, 5'd10);
    for (int i = 0; i < MULT_LAT; i++) begin
      #1;
      check("mult_busy", md_busy, 1);
      check("mult_stall", stall, 1);
      tick();
    end
    #1;
    check("mult_done_busy", md_busy, 0);
    check("mult_done_stall", stall, 0);
    tick();
    drain();

    // div then mflo: DIV_LAT cycles
    hilo(1'b1, 1'b1, 5'd0); tick();
    hilo(1'b0, 1'b0, 5'd10);
    for (int i = 0; i < DIV_LAT; i++) begin
      #1;
      check("div_stall", stall, 1);
      tick();
    end
    #1;
    check("div_done_stall", stall, 0);
    tick();
    drain();

    // a flush does not cancel a running multiply
    hilo(1'b1, 1'b0, 5'd0); tick();
    idle(); flush = 1'b1; tick(); flush = 1'b0; #1;
    check("flush_keeps_md", md_busy, 1);
    repeat (5) tick();

    // lw $7 in E is flushed: dependent addu sees nothing
    instr(5'd1, 5'd0, TUSE_ALU, TUSE_NONE, 5'd7, TNEW_LOAD); tick();
    idle(); flush = 1'b1; tick(); flush = 1'b0;
    instr(5'd1, 5'd7, TUSE_ALU, TUSE_ALU, 5'd3, TNEW_CALC); #1;
    check("flush_stall", stall, 0);
    check("flush_fwd_rt", fwd_rt_sel, 0);
    tick();
    drain();

    // flush coincident with issue: the entry is dropped
    instr(5'd1, 5'd0, TUSE_ALU, TUSE_NONE, 5'd7, TNEW_LOAD); flush = 1'b1; tick(); flush = 1'b0;
    instr(5'd1, 5'd7, TUSE_ALU, TUSE_ALU, 5'd3, TNEW_CALC); #1;
    check("flush_issue_stall", stall, 0);
    check("flush_issue_fwd_rt", fwd_rt_sel, 0);
    tick();
    drain();

    // a stall does not block the flush
    instr(5'd1, 5'd0, TUSE_ALU, TUSE_NONE, 5'd7, TNEW_LOAD); tick();
    instr(5'd1, 5'd7, TUSE_ALU, TUSE_ALU, 5'd3, TNEW_CALC); flush = 1'b1; #1;
    check("stall_under_flush", stall, 1);
    tick(); flush = 1'b0; #1;
    check("after_flush_stall", stall, 0);
    check("after_flush_fwd_rt", fwd_rt_sel, 0);
    tick();
    drain();

    // reset asserted mid-divide (count = 6): busy and stall drop at once
    hilo(1'b1, 1'b1, 5'd0); tick();
    hilo(1'b0, 1'b0, 5'd10);
    repeat (4) tick();
    #1;
    check("pre_reset_busy", md_busy, 1);
    check("pre_reset_stall", stall, 1);
    reset = 1'b0;
    model_reset();
    #1;
    check("rst_busy", md_busy, 0);
    check("rst_stall", stall, 0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("post_rst_stall", stall, 0);
    tick();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got time %0t, required finish before 100000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
